bus_cycle_controller: RTL and testbench
=======================================

Name: bus_cycle_controller

Overview:
Sequences every access on the 8-bit machine's shared 16-bit address / 8-bit data bus and arbitrates it between two requesters: CPU and DMA. Decodes the granted address into active-low RAM/IO/ROM chip selects using the system memory map. Drives setup/strobe/hold timing with per-region wait states, then returns a one-cycle acknowledge and the read data to the granted requester.

Parameters:
RAM_WS, 0, extra strobe cycles for RAM accesses
IO_WS, 2, extra strobe cycles for IO accesses
ROM_WS, 1, extra strobe cycles for ROM accesses
WS_W, 4, wait-state counter width; each *_WS must be at most 2^WS_W-1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU request; held high until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  16  CPU address
cpu_wdata  in  8  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  8  CPU read data
dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata  same directions, widths and meanings as the cpu_* ports
bus_addr  out  16  registered bus address
bus_wdata  out  8  registered bus write data
bus_rdata  in  8  bus read data
bus_oe_n  out  1  read strobe, active low
bus_we_n  out  1  write strobe, active low
ram_cs_n  out  1  RAM select, active low
io_cs_n  out  1  IO select, active low
rom_cs_n  out  1  ROM select, active low
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: state IDLE; all *_cs_n, bus_oe_n and bus_we_n = 1; acks = 0; busy = 0; bus_addr and bus_wdata = 0; both rdata = 0; last_grant = DMA.
- Memory map:
  - ROM when addr[15:13] = 3'b111 (E000-FFFF).
  - IO when addr[15:12] = 4'hD (D000-DFFF).
  - RAM otherwise (0000-CFFF).
  - Exactly one cs_n is low from SETUP through HOLD; all are high in IDLE.
- States:
  - IDLE: sample requests. If neither is pending, stay.
    - If one is pending, grant it.
    - If both are pending, grant the requester that is not last_grant (round robin), then update last_grant.
    - On grant, register addr, we, wdata and region. Load the wait counter with that region's WS. Go to SETUP.
  - SETUP (1 cycle): bus_addr valid; region cs_n low; both strobes high. Go to STROBE.
  - STROBE (1+WS cycles): read drives bus_oe_n low; write drives bus_we_n low.
    - A write to ROM leaves bus_we_n high and is silently discarded, but is still acked.
    - Counter decrements each cycle. At counter = 0, go to HOLD.
    - On a read, bus_rdata is latched into the granted requester's rdata on that same edge.
  - HOLD (1 cycle): strobes high; cs_n and bus_addr held; granted ack = 1. Go to IDLE.
- Latency: request sampled at edge e0 → ack high during the cycle after edge e(2+WS) → IDLE after e(3+WS).
  - Per-request cycle count: RAM 3, ROM 4, IO 5 at defaults.
  - A request still high at the next IDLE edge starts a new cycle, giving back-to-back accesses with no bubble beyond IDLE.
- Protocol rules:
  - Requesters hold req, addr, we and wdata stable until they see ack, then drop req within one cycle.
  - Dropping req or changing addr mid-cycle has no effect: registered values are used and ack still pulses.
- rdata of each requester holds its last read value; writes and the other requester's reads do not change it.
- Reset asserted mid-cycle: all outputs return to reset values immediately; no ack is issued; the aborted requester must re-request.

Decomposition:
- Package bus_cycle_pkg holds:
  - state enum (IDLE, SETUP, STROBE, HOLD);
  - region enum (RAM, IO, ROM);
  - requester enum (CPU, DMA);
  - function decode_region(addr) → region.
- One sub-module, bus_arbiter_rr: two-input round-robin grant with last_grant register, evaluated only in IDLE.
- FSM, wait counter and datapath registers stay in bus_cycle_controller.

Test Plan:
- CPU read 0x1234 (RAM), bus_rdata = 0xA5 → ram_cs_n low 3 cycles; bus_oe_n low 1 cycle; cpu_ack at cycle 3; cpu_rdata = 0xA5; dma_rdata unchanged.
- DMA write 0xD010 = 0x3C (IO) → io_cs_n low; bus_we_n low 3 cycles; bus_wdata = 0x3C; dma_ack at cycle 5.
- CPU write 0xF000 (ROM) → rom_cs_n low 4 cycles; bus_we_n stays 1; cpu_ack at cycle 4.
- CPU and DMA both request RAM continuously from reset → grants alternate CPU, DMA, CPU, DMA; each ack separated by 3 cycles; no gap cycles besides IDLE.
- rst_n pulsed low during STROBE of an IO read → all cs_n and strobes high asynchronously; no ack; after release, the held request restarts from SETUP and completes normally.
- Address boundary sweep 0xCFFF, 0xD000, 0xDFFF, 0xE000 → selects RAM, IO, IO, ROM respectively, with matching wait-state lengths 3/5/5/4.

Source files
------------

// File: rtl/bus_cycle_controller_pkg.sv
// -----------------------------------------------------------------------------
// bus_cycle_pkg
// Shared types for the bus cycle controller: FSM states, memory-map regions,
// requester identities and the address decoder used at grant time.
// -----------------------------------------------------------------------------
package bus_cycle_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RAM = 2'd0,
    IO  = 2'd1,
    ROM = 2'd2
  } region_e;

  typedef enum logic {
    CPU = 1'b0,
    DMA = 1'b1
  } requester_e;

  // Memory map only depends on the top nibble of the address:
  //   E000-FFFF ROM, D000-DFFF IO, 0000-CFFF RAM.
  function automatic region_e decode_region(input logic [3:0] addr_hi);
    region_e region;
    if (addr_hi[3:1] == 3'b111) begin
      region = ROM;
    end else if (addr_hi == 4'hD) begin
      region = IO;
    end else begin
      region = RAM;
    end
    return region;
  endfunction

endpackage

// File: rtl/bus_cycle_controller_if.sv
// -----------------------------------------------------------------------------
// bus_cycle_controller_if
// Groups the two requester handshakes and the shared external bus pins.
//   master : controller side (takes requests, drives bus, returns ack/rdata)
//   slave  : requester/bus-model side (drives requests and bus_rdata)
// Requester ports (cpu_*, dma_*): req, we, addr[15:0], wdata[7:0] in;
//   ack, rdata[7:0] out.
// Bus ports: bus_addr[15:0], bus_wdata[7:0], bus_oe_n, bus_we_n, ram_cs_n,
//   io_cs_n, rom_cs_n, busy out; bus_rdata[7:0] in.
// -----------------------------------------------------------------------------
interface bus_cycle_controller_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;

  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_ack;
  logic [7:0]  dma_rdata;

  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_oe_n;
  logic        bus_we_n;
  logic        ram_cs_n;
  logic        io_cs_n;
  logic        rom_cs_n;
  logic        busy;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output bus_addr, bus_wdata, bus_oe_n, bus_we_n,
    output ram_cs_n, io_cs_n, rom_cs_n, busy,
    input  bus_rdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  bus_addr, bus_wdata, bus_oe_n, bus_we_n,
    input  ram_cs_n, io_cs_n, rom_cs_n, busy,
    output bus_rdata
  );

endinterface

// File: rtl/bus_cycle_controller_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr
// Two-input round-robin arbiter. Grant is combinational from the requests and
// the last_grant register; last_grant only advances when the controller is
// in IDLE (en = 1) and actually accepts a grant.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   en                  controller is in IDLE and will take the grant
//   cpu_req, dma_req    pending requests
//   grant_vld           at least one request pending
//   grant               requester that wins this evaluation
// -----------------------------------------------------------------------------
module bus_arbiter_rr
  import bus_cycle_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       cpu_req,
  input  logic       dma_req,
  output logic       grant_vld,
  output requester_e grant
);

  requester_e last_grant_q;
  requester_e last_grant_d;

  always_comb begin
    grant_vld    = cpu_req | dma_req;
    grant        = CPU;
    last_grant_d = last_grant_q;

    if (cpu_req && dma_req) begin
      grant = (last_grant_q == CPU) ? DMA : CPU;
    end else if (dma_req) begin
      grant = DMA;
    end

    // Any accepted grant becomes the new "last" so a lone requester does not
    // starve the other once both contend again.
    if (en && grant_vld) begin
      last_grant_d = grant;
    end
  end

  // Reset to DMA so the first contended grant after reset goes to the CPU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= DMA;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/bus_cycle_controller.sv
// -----------------------------------------------------------------------------
// bus_cycle_controller
// Sequences every access on the shared 16-bit address / 8-bit data bus,
// arbitrating between CPU and DMA. The granted address is decoded into one
// active-low chip select; the cycle runs SETUP, STROBE (1 + region wait
// states) and HOLD, where a one-cycle ack is returned to the owner.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bif    master modport of bus_cycle_controller_if (requesters + bus pins)
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no cycle; arbitrate and register the granted request
//   SETUP  | address and chip select valid, strobes inactive (1 cycle)
//   STROBE | oe_n or we_n active; wait counter runs down to 0 (1+WS cycles)
//   HOLD   | strobes released, cs/addr held, owner ack = 1 (1 cycle)
// -----------------------------------------------------------------------------
module bus_cycle_controller
  import bus_cycle_pkg::*;
#(
  parameter int RAM_WS = 0,
  parameter int IO_WS  = 2,
  parameter int ROM_WS = 1,
  parameter int WS_W   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bus_cycle_controller_if.master bif
);

  localparam logic [WS_W-1:0] RAM_WS_L = WS_W'(RAM_WS);
  localparam logic [WS_W-1:0] IO_WS_L  = WS_W'(IO_WS);
  localparam logic [WS_W-1:0] ROM_WS_L = WS_W'(ROM_WS);

  function automatic logic [WS_W-1:0] ws_for(input region_e region);
    logic [WS_W-1:0] ws;
    case (region)
      IO:      ws = IO_WS_L;
      ROM:     ws = ROM_WS_L;
      default: ws = RAM_WS_L;
    endcase
    return ws;
  endfunction

  state_e          state_q,     state_d;
  logic [WS_W-1:0] ws_cnt_q,    ws_cnt_d;
  logic [15:0]     addr_q,      addr_d;
  logic [7:0]      wdata_q,     wdata_d;
  logic            we_q,        we_d;
  region_e         region_q,    region_d;
  requester_e      owner_q,     owner_d;
  logic [7:0]      cpu_rdata_q, cpu_rdata_d;
  logic [7:0]      dma_rdata_q, dma_rdata_d;

  logic            arb_en;
  logic            grant_vld;
  requester_e      grant;
  logic [15:0]     sel_addr;
  logic [7:0]      sel_wdata;
  logic            sel_we;
  region_e         sel_region;

  assign arb_en = (state_q == IDLE);

  bus_arbiter_rr u_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (arb_en),
    .cpu_req   (bif.cpu_req),
    .dma_req   (bif.dma_req),
    .grant_vld (grant_vld),
    .grant     (grant)
  );

  always_comb begin
    sel_addr   = bif.cpu_addr;
    sel_wdata  = bif.cpu_wdata;
    sel_we     = bif.cpu_we;
    if (grant == DMA) begin
      sel_addr  = bif.dma_addr;
      sel_wdata = bif.dma_wdata;
      sel_we    = bif.dma_we;
    end
    sel_region = decode_region(sel_addr[15:12]);
  end

  always_comb begin
    state_d     = state_q;
    ws_cnt_d    = ws_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    region_d    = region_q;
    owner_d     = owner_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          owner_d  = grant;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          we_d     = sel_we;
          region_d = sel_region;
          ws_cnt_d = ws_for(sel_region);
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = STROBE;
      end
      STROBE: begin
        if (ws_cnt_q == '0) begin
          state_d = HOLD;
          // Capture read data on the edge that ends the strobe.
          if (!we_q) begin
            if (owner_q == CPU) begin
              cpu_rdata_d = bif.bus_rdata;
            end else begin
              dma_rdata_d = bif.bus_rdata;
            end
          end
        end else begin
          ws_cnt_d = ws_cnt_q - 1'b1;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ws_cnt_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      region_q    <= RAM;
      owner_q     <= CPU;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ws_cnt_q    <= ws_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      region_q    <= region_d;
      owner_q     <= owner_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Strobes and selects decode straight from registered state, so reset
  // drives them inactive asynchronously.
  logic cycle_active;
  logic in_strobe;
  logic in_hold;

  assign cycle_active = (state_q != IDLE);
  assign in_strobe    = (state_q == STROBE);
  assign in_hold      = (state_q == HOLD);

  assign bif.ram_cs_n = !(cycle_active && region_q == RAM);
  assign bif.io_cs_n  = !(cycle_active && region_q == IO);
  assign bif.rom_cs_n = !(cycle_active && region_q == ROM);

  assign bif.bus_oe_n = !(in_strobe && !we_q);
  // ROM writes run the full cycle and are acked, but never assert we_n.
  assign bif.bus_we_n = !(in_strobe && we_q && region_q != ROM);

  assign bif.bus_addr  = addr_q;
  assign bif.bus_wdata = wdata_q;
  assign bif.busy      = cycle_active;

  assign bif.cpu_ack   = in_hold && (owner_q == CPU);
  assign bif.dma_ack   = in_hold && (owner_q == DMA);
  assign bif.cpu_rdata = cpu_rdata_q;
  assign bif.dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_bus_cycle_controller.sv
module tb_bus_cycle_controller;

  logic clk;
  logic rst_n;

  bus_cycle_controller_if bif();

  bus_cycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One access by a single requester. Cycle 1 is the negedge after the
  // grant edge; counts cover cycles 1..ack.
  task automatic access(input string tag, input bit is_dma, input bit we,
                        input logic [15:0] addr, input logic [7:0] wd, input logic [7:0] rd,
                        input int exp_ack, input int exp_ram, input int exp_io, input int exp_rom,
                        input int exp_oe, input int exp_we,
                        input logic [7:0] exp_own_rd, input logic [7:0] exp_other_rd);
    int ram_n, io_n, rom_n, oe_n, we_n, ack_cyc, other_ack;
    logic [15:0] addr_seen;
    logic [7:0]  wd_seen;
    ram_n = 0; io_n = 0; rom_n = 0; oe_n = 0; we_n = 0; ack_cyc = 0; other_ack = 0;
    addr_seen = '0; wd_seen = '0;
    bif.bus_rdata = rd;
    if (is_dma) begin
      bif.dma_req = 1'b1; bif.dma_we = we; bif.dma_addr = addr; bif.dma_wdata = wd;
    end else begin
      bif.cpu_req = 1'b1; bif.cpu_we = we; bif.cpu_addr = addr; bif.cpu_wdata = wd;
    end
    for (int c = 1; c <= 20 && ack_cyc == 0; c++) begin
      @(negedge clk);
      if (!bif.ram_cs_n) ram_n++;
      if (!bif.io_cs_n)  io_n++;
      if (!bif.rom_cs_n) rom_n++;
      if (!bif.bus_oe_n) oe_n++;
      if (!bif.bus_we_n) we_n++;
      if ((is_dma ? bif.cpu_ack : bif.dma_ack) === 1'b1) other_ack++;
      if ((is_dma ? bif.dma_ack : bif.cpu_ack) === 1'b1) begin
        ack_cyc   = c;
        addr_seen = bif.bus_addr;
        wd_seen   = bif.bus_wdata;
        bif.cpu_req = 1'b0;
        bif.dma_req = 1'b0;
      end
    end
    bif.cpu_req = 1'b0;
    bif.dma_req = 1'b0;
    check({tag, "_ack_cycle"}, ack_cyc, exp_ack);
    check({tag, "_ram_cs_cycles"}, ram_n, exp_ram);
    check({tag, "_io_cs_cycles"}, io_n, exp_io);
    check({tag, "_rom_cs_cycles"}, rom_n, exp_rom);
    check({tag, "_oe_cycles"}, oe_n, exp_oe);
    check({tag, "_we_cycles"}, we_n, exp_we);
    check({tag, "_other_ack"}, other_ack, 0);
    check({tag, "_bus_addr"}, addr_seen, addr);
    if (we) check({tag, "_bus_wdata"}, wd_seen, wd);
    check({tag, "_own_rdata"}, is_dma ? bif.dma_rdata : bif.cpu_rdata, exp_own_rd);
    check({tag, "_other_rdata"}, is_dma ? bif.cpu_rdata : bif.dma_rdata, exp_other_rd);
    @(negedge clk);
    check({tag, "_idle_after"}, {bif.busy, bif.ram_cs_n, bif.io_cs_n, bif.rom_cs_n}, 4'b0111);
  endtask

  logic [16:0] cpu_vec, dma_vec;
  logic [15:0] cpu_addr_seen, dma_addr_seen;

  initial begin
    rst_n = 1'b0;
    bif.cpu_req = 1'b0; bif.cpu_we = 1'b0; bif.cpu_addr = '0; bif.cpu_wdata = '0;
    bif.dma_req = 1'b0; bif.dma_we = 1'b0; bif.dma_addr = '0; bif.dma_wdata = '0;
    bif.bus_rdata = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_strobes_cs", {bif.ram_cs_n, bif.io_cs_n, bif.rom_cs_n, bif.bus_oe_n, bif.bus_we_n}, 5'h1f);
    check("rst_busy_acks", {bif.busy, bif.cpu_ack, bif.dma_ack}, 3'b000);
    check("rst_bus_addr", bif.bus_addr, 16'h0000);
    check("rst_bus_wdata", bif.bus_wdata, 8'h00);
    check("rst_rdata", {bif.cpu_rdata, bif.dma_rdata}, 16'h0000);

    // Both requesters read RAM continuously from reset: CPU, DMA, CPU, DMA.
    bif.cpu_req = 1'b1; bif.cpu_we = 1'b0; bif.cpu_addr = 16'h0100;
    bif.dma_req = 1'b1; bif.dma_we = 1'b0; bif.dma_addr = 16'h0200;
    bif.bus_rdata = 8'h5A;
    @(negedge clk);
    rst_n = 1'b1;
    cpu_vec = '0; dma_vec = '0; cpu_addr_seen = '0; dma_addr_seen = '0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      cpu_vec[c] = bif.cpu_ack;
      dma_vec[c] = bif.dma_ack;
      if (bif.cpu_ack === 1'b1) cpu_addr_seen = bif.bus_addr;
      if (bif.dma_ack === 1'b1) dma_addr_seen = bif.bus_addr;
    end
    bif.cpu_req = 1'b0; bif.dma_req = 1'b0;
    check("rr_cpu_ack_pattern", cpu_vec, 17'h00808);
    check("rr_dma_ack_pattern", dma_vec, 17'h08080);
    check("rr_cpu_addr", cpu_addr_seen, 16'h0100);
    check("rr_dma_addr", dma_addr_seen, 16'h0200);
    check("rr_rdata", {bif.cpu_rdata, bif.dma_rdata}, 16'h5A5A);
    @(negedge clk);
    check("rr_idle_after", bif.busy, 1'b0);

    // Single accesses.
    access("cpu_rd_ram", 1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5, 3, 3, 0, 0, 1, 0, 8'hA5, 8'h5A);
    access("dma_wr_io",  1'b1, 1'b1, 16'hD010, 8'h3C, 8'hEE, 5, 0, 5, 0, 0, 3, 8'h5A, 8'hA5);
    access("cpu_wr_rom", 1'b0, 1'b1, 16'hF000, 8'h99, 8'hEE, 4, 0, 0, 4, 0, 0, 8'hA5, 8'h5A);

    // Address boundary sweep.
    access("bnd_cfff", 1'b0, 1'b0, 16'hCFFF, 8'h00, 8'h11, 3, 3, 0, 0, 1, 0, 8'h11, 8'h5A);
    access("bnd_d000", 1'b0, 1'b0, 16'hD000, 8'h00, 8'h22, 5, 0, 5, 0, 3, 0, 8'h22, 8'h5A);
    access("bnd_dfff", 1'b0, 1'b0, 16'hDFFF, 8'h00, 8'h33, 5, 0, 5, 0, 3, 0, 8'h33, 8'h5A);
    access("bnd_e000", 1'b0, 1'b0, 16'hE000, 8'h00, 8'h44, 4, 0, 0, 4, 2, 0, 8'h44, 8'h5A);

    // Reset pulsed during STROBE of a DMA IO read.
    bif.dma_req = 1'b1; bif.dma_we = 1'b0; bif.dma_addr = 16'hD100; bif.bus_rdata = 8'h77;
    repeat (3) @(negedge clk);
    check("rstmid_in_strobe", {bif.io_cs_n, bif.bus_oe_n, bif.busy}, 3'b001);
    rst_n = 1'b0;
    #1;
    check("rstmid_strobes_cs", {bif.ram_cs_n, bif.io_cs_n, bif.rom_cs_n, bif.bus_oe_n, bif.bus_we_n}, 5'h1f);
    check("rstmid_busy_acks", {bif.busy, bif.cpu_ack, bif.dma_ack}, 3'b000);
    check("rstmid_rdata", {bif.cpu_rdata, bif.dma_rdata}, 16'h0000);
    @(negedge clk);
    check("rstmid_no_ack", {bif.busy, bif.cpu_ack, bif.dma_ack}, 3'b000);
    rst_n = 1'b1;
    access("rstmid_restart", 1'b1, 1'b0, 16'hD100, 8'h00, 8'h77, 5, 0, 5, 0, 3, 0, 8'h77, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
